// File: rtl/ex_mem_buf.sv
// Execute-to-memory stage buffer: a 2-entry in-order queue between the ALU
// and the memory stage, plus a forwarding tap, architectural condition codes
// and sticky halt detection.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high (and flush is low). The producer may change its data only after a
// transfer or while valid is low. in_ready comes from registered state only,
// and out_* comes from storage only, so no input reaches an output
// combinationally.
module ex_mem_buf #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic              in_ofl,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              in_p,
  input  logic              in_cout,
  input  logic [DATA_W-1:0] in_st_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_we,
  input  logic              in_mem_re,
  input  logic              in_mem_we,
  input  logic              in_set_cc,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_st_data,
  output logic              out_ofl,
  output logic              out_z,
  output logic              out_n,
  output logic              out_p,
  output logic              out_cout,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_we,
  output logic              out_mem_re,
  output logic              out_mem_we,
  output logic              out_halt,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              cc_z,
  output logic              cc_n,
  output logic              cc_p,
  output logic              halted
);

  // Entry layout, LSB first: halt, set_cc, mem_we, mem_re, reg_we, cout, p, n,
  // z, ofl, rd, st_data, alu_out.
  localparam int CTL_W  = 10;
  localparam int RD_LO  = CTL_W;
  localparam int ST_LO  = RD_LO + REG_W;
  localparam int ALU_LO = ST_LO + DATA_W;
  localparam int ENT_W  = ALU_LO + DATA_W;

  logic [ENT_W-1:0] mem_q [2];
  logic [ENT_W-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             cc_z_q, cc_z_d;
  logic             cc_n_q, cc_n_d;
  logic             cc_p_q, cc_p_d;
  logic             halted_q, halted_d;

  logic             push;
  logic             pop;
  logic [ENT_W-1:0] in_entry;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] head_vis;

  // Handshake qualifiers and entry packing.
  always_comb begin
    in_ready  = (count_q != 2'd2) & ~halted_q;
    out_valid = (count_q != 2'd0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
    in_entry  = {in_alu_out, in_st_data, in_rd, in_ofl, in_z, in_n, in_p,
                 in_cout, in_reg_we, in_mem_re, in_mem_we, in_set_cc, in_halt};
    head      = mem_q[rd_ptr_q];
  end

  // Next-state: queue pointers/count, storage writes, cc and halt updates on pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    cc_z_d   = cc_z_q;
    cc_n_d   = cc_n_q;
    cc_p_d   = cc_p_q;
    halted_d = halted_q;
    if (flush) begin
      // Drop everything; architectural state is left alone.
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        if (head[1]) begin
          cc_z_d = head[8];
          cc_n_d = head[7];
          cc_p_d = head[6];
        end
        if (head[0]) halted_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      cc_z_q   <= 1'b1;
      cc_n_q   <= 1'b0;
      cc_p_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cc_z_q   <= cc_z_d;
      cc_n_q   <= cc_n_d;
      cc_p_q   <= cc_p_d;
      halted_q <= halted_d;
    end
  end

  // Head fields, forced to zero when nothing valid is presented.
  always_comb begin
    head_vis    = out_valid ? head : '0;
    out_alu_out = head_vis[ALU_LO +: DATA_W];
    out_st_data = head_vis[ST_LO +: DATA_W];
    out_rd      = head_vis[RD_LO +: REG_W];
    out_ofl     = head_vis[9];
    out_z       = head_vis[8];
    out_n       = head_vis[7];
    out_p       = head_vis[6];
    out_cout    = head_vis[5];
    out_reg_we  = head_vis[4];
    out_mem_re  = head_vis[3];
    out_mem_we  = head_vis[2];
    out_halt    = head_vis[0];
    fwd_valid   = out_valid & head_vis[4];
    fwd_rd      = head_vis[RD_LO +: REG_W];
    fwd_data    = head_vis[ALU_LO +: DATA_W];
    cc_z        = cc_z_q;
    cc_n        = cc_n_q;
    cc_p        = cc_p_q;
    halted      = halted_q;
  end

endmodule

// File: tb/tb_ex_mem_buf.sv
// Directed bench for ex_mem_buf. The stimulus flow pushes the expected head
// record for every entry it knows will be accepted; a negedge monitor pops and
// compares on every consumed head and checks zeroed outputs while idle.
module tb_ex_mem_buf;

  localparam int W = 44;  // {alu, st, rd, ofl, z, n, p, cout, reg_we, mem_re, mem_we, halt}

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [15:0] in_alu_out, in_st_data;
  logic        in_ofl, in_z, in_n, in_p, in_cout;
  logic [2:0]  in_rd;
  logic        in_reg_we, in_mem_re, in_mem_we, in_set_cc, in_halt;
  logic        out_valid, out_ready;
  logic [15:0] out_alu_out, out_st_data;
  logic        out_ofl, out_z, out_n, out_p, out_cout;
  logic [2:0]  out_rd;
  logic        out_reg_we, out_mem_re, out_mem_we, out_halt;
  logic        fwd_valid;
  logic [2:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic        cc_z, cc_n, cc_p, halted;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         mon_en   = 1'b0;

  ex_mem_buf #(.DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_ofl(in_ofl), .in_z(in_z), .in_n(in_n), .in_p(in_p),
    .in_cout(in_cout), .in_st_data(in_st_data), .in_rd(in_rd), .in_reg_we(in_reg_we),
    .in_mem_re(in_mem_re), .in_mem_we(in_mem_we), .in_set_cc(in_set_cc), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_out(out_alu_out),
    .out_st_data(out_st_data), .out_ofl(out_ofl), .out_z(out_z), .out_n(out_n),
    .out_p(out_p), .out_cout(out_cout), .out_rd(out_rd), .out_reg_we(out_reg_we),
    .out_mem_re(out_mem_re), .out_mem_we(out_mem_we), .out_halt(out_halt),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .cc_z(cc_z), .cc_n(cc_n), .cc_p(cc_p), .halted(halted)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] head_now();
    return {out_alu_out, out_st_data, out_rd, out_ofl, out_z, out_n, out_p, out_cout,
            out_reg_we, out_mem_re, out_mem_we, out_halt};
  endfunction

  // Driver: ctl = {ofl, z, n, p, cout, reg_we, mem_re, mem_we, set_cc, halt}.
  // accept is the hand-decided outcome of this push.
  task automatic drive(input logic [15:0] alu, input logic [15:0] st, input logic [2:0] rd,
                       input logic [9:0] ctl, input bit accept);
    in_valid   = 1'b1;
    in_alu_out = alu;
    in_st_data = st;
    in_rd      = rd;
    {in_ofl, in_z, in_n, in_p, in_cout, in_reg_we, in_mem_re, in_mem_we,
     in_set_cc, in_halt} = ctl;
    if (accept) exp_q.push_back({alu, st, rd, ctl[9:2], ctl[0]});
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_alu_out = 16'h0; in_st_data = 16'h0; in_rd = 3'd0;
    {in_ofl, in_z, in_n, in_p, in_cout, in_reg_we, in_mem_re, in_mem_we,
     in_set_cc, in_halt} = 10'h0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (out_ready && !flush) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pop: got %0h expected none", head_now());
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("head", 64'(head_now()), 64'(e));
            chk("fwd", {45'd0, fwd_valid, fwd_rd, fwd_data}, {45'd0, e[3], e[11:9], e[43:28]});
          end
        end
      end else begin
        chk("idle_zero", {16'd0, head_now(), fwd_valid, fwd_rd, fwd_data}, 64'd0);
      end
    end
  end

  initial begin
    // Reset with garbage presented
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(16'hFFFF, 16'hFFFF, 3'd7, 10'h3FF, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cc", {61'd0, cc_z, cc_n, cc_p}, 64'b100);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_outs", {16'd0, head_now(), fwd_valid, fwd_rd, fwd_data}, 64'd0);
    rst = 1'b0;
    idle_in();
    mon_en = 1'b1;
    tick();

    // Pass-through
    out_ready = 1'b1;
    drive(16'h1234, 16'h0000, 3'd5, 10'h010, 1'b1);
    tick();
    idle_in();
    chk("pt_out_valid", 64'(out_valid), 64'd1);
    chk("pt_alu", 64'(out_alu_out), 64'h1234);
    chk("pt_fwd", {60'd0, fwd_valid, fwd_rd}, {60'd0, 1'b1, 3'd5});
    tick();
    chk("pt_drained", 64'(out_valid), 64'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(16'h0001, 16'hBEEF, 3'd1, 10'h004, 1'b1);
    tick();
    chk("bp_ready1", 64'(in_ready), 64'd1);
    drive(16'h0002, 16'hCAFE, 3'd2, 10'h008, 1'b1);
    tick();
    chk("bp_full", 64'(in_ready), 64'd0);
    drive(16'h0003, 16'hDEAD, 3'd3, 10'h010, 1'b0);
    tick();
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_head1", 64'(out_alu_out), 64'h0001);
    idle_in();
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    chk("bp_head2", 64'(out_alu_out), 64'h0002);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Streaming at count 1
    for (int i = 0; i < 8; i++) begin
      drive(16'(i), ~16'(i), 3'(i), 10'h030, 1'b1);
      tick();
      chk("st_ready", 64'(in_ready), 64'd1);
      chk("st_head", 64'(out_alu_out), 64'(i));
    end
    idle_in();
    tick();
    chk("st_drained", 64'(out_valid), 64'd0);

    // Flush with two buffered and one presented
    out_ready = 1'b0;
    drive(16'h00A1, 16'h0, 3'd1, 10'h012, 1'b0);
    tick();
    drive(16'h00A2, 16'h0, 3'd2, 10'h182, 1'b0);
    tick();
    chk("fl_full", 64'(in_ready), 64'd0);
    drive(16'h00A3, 16'h0, 3'd3, 10'h012, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_cc", {61'd0, cc_z, cc_n, cc_p}, 64'b100);
    out_ready = 1'b1;
    tick();
    chk("fl_stays_empty", 64'(out_valid), 64'd0);

    // Condition codes
    drive(16'h0055, 16'h0, 3'd4, 10'h082, 1'b1);  // set_cc, n=1
    tick();
    idle_in();
    tick();
    chk("cc_set", {61'd0, cc_z, cc_n, cc_p}, 64'b010);
    drive(16'h0066, 16'h0, 3'd4, 10'h100, 1'b1);  // z=1, no set_cc
    tick();
    idle_in();
    tick();
    chk("cc_hold", {61'd0, cc_z, cc_n, cc_p}, 64'b010);

    // Halt: halt entry followed by one more that must still drain
    out_ready = 1'b0;
    drive(16'h0077, 16'h0, 3'd6, 10'h001, 1'b1);
    tick();
    drive(16'h0088, 16'h1111, 3'd7, 10'h014, 1'b1);
    tick();
    idle_in();
    out_ready = 1'b1;
    tick();
    chk("halt_set", 64'(halted), 64'd1);
    chk("halt_in_ready", 64'(in_ready), 64'd0);
    chk("halt_drain_valid", 64'(out_valid), 64'd1);
    drive(16'h0099, 16'h0, 3'd1, 10'h010, 1'b0);
    tick();
    chk("halt_drained", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("halt_sticky", {62'd0, halted, in_ready}, 64'b10);
    idle_in();

    // Reset clears halt
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_halted", 64'(halted), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    chk("rst2_cc", {61'd0, cc_z, cc_n, cc_p}, 64'b100);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
